rv_csr_ctrl: RTL and testbench

Sequencer in front of the CSR data block of the execute stage. Accepts one CSR instruction at a time from the CSR issue path and performs the atomic read-modify-write as separate read and write cycles. Holds off fflags/fcsr accesses while the warp still has FPU operations in flight. Returns the old CSR value to commit over a valid/ready response channel.

---
 rtl/rv_csr_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_rv_csr_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_csr_ctrl.sv
// rv_csr_ctrl: CSR read-modify-write sequencer for the execute stage.
// Accepts one CSR instruction at a time, holds fflags/fcsr accesses until the
// issuing warp has no FPU operations in flight, performs the read and the
// write as separate single-cycle pulses, and returns the pre-write CSR value
// over a valid/ready response channel.
// Optional feature macro: RV_CSR_CTRL_PERF_EN (FPU-stall and CSR-write
// saturating performance counters).

`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef CSR_ADDR_BITS
`define CSR_ADDR_BITS 12
`endif

module rv_csr_ctrl #(
  parameter int NUM_WARPS      = `NUM_WARPS,
  parameter int NW_BITS        = `NW_BITS,
  parameter int UUID_BITS      = `UUID_BITS,
  parameter int ADDR_BITS      = `CSR_ADDR_BITS
`ifdef RV_CSR_CTRL_PERF_EN
  , parameter int STALL_CNT_BITS = 16
`endif
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [UUID_BITS-1:0]      req_uuid,
  input  logic [NW_BITS-1:0]        req_wid,
  input  logic [ADDR_BITS-1:0]      req_addr,
  input  logic [1:0]                req_op,
  input  logic [31:0]               req_operand,

  input  logic [NUM_WARPS-1:0]      fpu_pending,

  output logic                      csr_read_enable,
  output logic [UUID_BITS-1:0]      csr_read_uuid,
  output logic [ADDR_BITS-1:0]      csr_read_addr,
  output logic [NW_BITS-1:0]        csr_read_wid,
  input  logic [31:0]               csr_read_data,

  output logic                      csr_write_enable,
  output logic [UUID_BITS-1:0]      csr_write_uuid,
  output logic [ADDR_BITS-1:0]      csr_write_addr,
  output logic [NW_BITS-1:0]        csr_write_wid,
  output logic [31:0]               csr_write_data,

  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [UUID_BITS-1:0]      rsp_uuid,
  output logic [NW_BITS-1:0]        rsp_wid,
  output logic [31:0]               rsp_data,

  output logic                      busy
`ifdef RV_CSR_CTRL_PERF_EN
  , output logic [STALL_CNT_BITS-1:0] perf_fpu_stall_cycles,
  output logic [STALL_CNT_BITS-1:0] perf_csr_writes
`endif
);

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FPU,
    S_READ,
    S_WRITE,
    S_RESP
  } state_e;

  localparam logic [ADDR_BITS-1:0] ADDR_FFLAGS = ADDR_BITS'(12'h001);
  localparam logic [ADDR_BITS-1:0] ADDR_FCSR   = ADDR_BITS'(12'h003);

  state_e                 state_q;
  csr_op_e                op_q;
  logic [UUID_BITS-1:0]   uuid_q;
  logic [NW_BITS-1:0]     wid_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [31:0]            operand_q;
  logic [31:0]            old_q;
  logic [31:0]            wdata_q;
  logic                   read_en_q;
  logic                   write_en_q;
  logic                   rsp_valid_q;
  logic                   req_ready_q;
  logic                   busy_q;

  logic [31:0]            wdata_d;
  logic                   write_needed;
  logic                   fp_addr_req;

  // Only the FP status CSRs depend on outstanding FPU results; frm never waits.
  assign fp_addr_req = (req_addr == ADDR_FFLAGS) || (req_addr == ADDR_FCSR);

  // RS/RC with a zero mask are architecturally read-only; op 00 never writes.
  assign write_needed = (op_q == OP_RW) ||
                        (((op_q == OP_RS) || (op_q == OP_RC)) && (operand_q != 32'd0));

  // New CSR value from the value being read this cycle (becomes old_q).
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    wdata_d = csr_read_data;
    unique case (op_q)
      OP_RW:   wdata_d = operand_q;
      OP_RS:   wdata_d = csr_read_data | operand_q;
      OP_RC:   wdata_d = csr_read_data & ~operand_q;
      default: wdata_d = csr_read_data;
    endcase
  end

  // Sequencer FSM with registered handshake and CSR-port strobes.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: the latched request fields are reset too, so the echoed ids and
  // CSR port fields read as zero out of reset and an aborted op leaves no trace.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_READ;
      uuid_q      <= '0;
      wid_q       <= '0;
      addr_q      <= '0;
      operand_q   <= '0;
      old_q       <= '0;
      wdata_q     <= '0;
      read_en_q   <= 1'b0;
      write_en_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      read_en_q  <= 1'b0;
      write_en_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            uuid_q      <= req_uuid;
            wid_q       <= req_wid;
            addr_q      <= req_addr;
            op_q        <= csr_op_e'(req_op);
            operand_q   <= req_operand;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (fp_addr_req && fpu_pending[req_wid]) begin
              state_q <= S_WAIT_FPU;
            end else begin
              state_q   <= S_READ;
              read_en_q <= 1'b1;
            end
          end
        end
        S_WAIT_FPU: begin
          if (!fpu_pending[wid_q]) begin
            state_q   <= S_READ;
            read_en_q <= 1'b1;
          end
        end
        S_READ: begin
          old_q      <= csr_read_data;
          wdata_q    <= wdata_d;
          write_en_q <= write_needed;
          state_q    <= S_WRITE;
        end
        S_WRITE: begin
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready        = req_ready_q;
  assign busy             = busy_q;

  assign csr_read_enable  = read_en_q;
  assign csr_read_uuid    = uuid_q;
  assign csr_read_addr    = addr_q;
  assign csr_read_wid     = wid_q;

  assign csr_write_enable = write_en_q;
  assign csr_write_uuid   = uuid_q;
  assign csr_write_addr   = addr_q;
  assign csr_write_wid    = wid_q;
  assign csr_write_data   = wdata_q;

  assign rsp_valid        = rsp_valid_q;
  assign rsp_uuid         = uuid_q;
  assign rsp_wid          = wid_q;
  assign rsp_data         = old_q;

`ifdef RV_CSR_CTRL_PERF_EN
  logic [STALL_CNT_BITS-1:0] stall_cnt_q;
  logic [STALL_CNT_BITS-1:0] write_cnt_q;

  // Saturating counters: cycles spent waiting on the FPU, and CSR write pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      write_cnt_q <= '0;
    end else begin
      if ((state_q == S_WAIT_FPU) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (write_en_q && (write_cnt_q != '1)) begin
        write_cnt_q <= write_cnt_q + 1'b1;
      end
    end
  end

  assign perf_fpu_stall_cycles = stall_cnt_q;
  assign perf_csr_writes       = write_cnt_q;
`endif

endmodule

// File: tb/tb_rv_csr_ctrl.sv
// tb_rv_csr_ctrl: scoreboard bench for rv_csr_ctrl. A driver issues directed
// and random CSR instructions, a reference model computes the expected
// read/write/response behaviour and queues it, and a negedge monitor checks
// what the DUT presents on its CSR and response ports.
// Optional feature macro: RV_CSR_CTRL_PERF_EN (also checks the perf counters).

module tb_rv_csr_ctrl;

  localparam int NUM_WARPS = 4;
  localparam int NW_BITS   = 2;
  localparam int UUID_BITS = 44;
  localparam int ADDR_BITS = 12;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   req_valid = 1'b0;
  logic                   req_ready;
  logic [UUID_BITS-1:0]   req_uuid = '0;
  logic [NW_BITS-1:0]     req_wid = '0;
  logic [ADDR_BITS-1:0]   req_addr = '0;
  logic [1:0]             req_op = '0;
  logic [31:0]            req_operand = '0;
  logic [NUM_WARPS-1:0]   fpu_pending = '0;
  logic                   csr_read_enable;
  logic [UUID_BITS-1:0]   csr_read_uuid;
  logic [ADDR_BITS-1:0]   csr_read_addr;
  logic [NW_BITS-1:0]     csr_read_wid;
  logic [31:0]            csr_read_data;
  logic                   csr_write_enable;
  logic [UUID_BITS-1:0]   csr_write_uuid;
  logic [ADDR_BITS-1:0]   csr_write_addr;
  logic [NW_BITS-1:0]     csr_write_wid;
  logic [31:0]            csr_write_data;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b0;
  logic [UUID_BITS-1:0]   rsp_uuid;
  logic [NW_BITS-1:0]     rsp_wid;
  logic [31:0]            rsp_data;
  logic                   busy;
`ifdef RV_CSR_CTRL_PERF_EN
  logic [15:0]            perf_fpu_stall_cycles;
  logic [15:0]            perf_csr_writes;
  int                     exp_stall = 0;
  int                     exp_writes = 0;
`endif

  rv_csr_ctrl #(
    .NUM_WARPS (NUM_WARPS),
    .NW_BITS   (NW_BITS),
    .UUID_BITS (UUID_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_uuid         (req_uuid),
    .req_wid          (req_wid),
    .req_addr         (req_addr),
    .req_op           (req_op),
    .req_operand      (req_operand),
    .fpu_pending      (fpu_pending),
    .csr_read_enable  (csr_read_enable),
    .csr_read_uuid    (csr_read_uuid),
    .csr_read_addr    (csr_read_addr),
    .csr_read_wid     (csr_read_wid),
    .csr_read_data    (csr_read_data),
    .csr_write_enable (csr_write_enable),
    .csr_write_uuid   (csr_write_uuid),
    .csr_write_addr   (csr_write_addr),
    .csr_write_wid    (csr_write_wid),
    .csr_write_data   (csr_write_data),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_uuid         (rsp_uuid),
    .rsp_wid          (rsp_wid),
    .rsp_data         (rsp_data),
    .busy             (busy)
`ifdef RV_CSR_CTRL_PERF_EN
    , .perf_fpu_stall_cycles (perf_fpu_stall_cycles),
    .perf_csr_writes         (perf_csr_writes)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Small CSR file: eight addresses the stimulus draws from.
  function automatic int aidx(input logic [11:0] a);
    case (a)
      12'h001: return 0;
      12'h002: return 1;
      12'h003: return 2;
      12'h341: return 3;
      12'h300: return 4;
      12'h305: return 5;
      12'h340: return 6;
      default: return 7;
    endcase
  endfunction

  function automatic logic [11:0] addr_of(input int i);
    case (i)
      0: return 12'h001;
      1: return 12'h002;
      2: return 12'h003;
      3: return 12'h341;
      4: return 12'h300;
      5: return 12'h305;
      6: return 12'h340;
      default: return 12'h342;
    endcase
  endfunction

  logic [31:0] ref_mem [8];   // what the CSRs should contain
  logic [31:0] dut_mem [8];   // what the DUT's writes actually produced
  logic        load_mem = 1'b1;

  always @(posedge clk) begin
    if (load_mem) dut_mem <= ref_mem;
    else if (csr_write_enable) dut_mem[aidx(csr_write_addr)] <= csr_write_data;
  end

  assign csr_read_data = dut_mem[aidx(csr_read_addr)];

  typedef struct {
    logic [UUID_BITS-1:0] uuid;
    logic [NW_BITS-1:0]   wid;
    logic [11:0]          addr;
    logic                 do_write;
    logic [31:0]          wdata;
    logic [31:0]          old;
    int                   read_cyc;
  } exp_t;

  exp_t exp_q[$];

  // ---------------- monitor ----------------
  logic                 mon_en = 1'b0;
  logic                 got_read, got_write, prev_valid, exp_idle;
  logic [31:0]          prev_data;
  logic [UUID_BITS-1:0] prev_uuid;
  logic [NW_BITS-1:0]   prev_wid;
  exp_t                 me;

  always @(negedge clk) begin
    if (!mon_en) begin
      got_read = 0; got_write = 0; prev_valid = 0; exp_idle = 0;
    end else begin
      if (exp_idle) begin
        check("idle_req_ready", req_ready, 1);
        check("idle_busy", busy, 0);
        exp_idle = 0;
      end
      check("rd_wr_overlap", csr_read_enable & csr_write_enable, 0);
      if (csr_read_enable) begin
        if (exp_q.size() == 0) check("unexpected_read", exp_q.size(), 1);
        else begin
          me = exp_q[0];
          check("read_cycle", cyc, me.read_cyc);
          check("read_addr", csr_read_addr, me.addr);
          check("read_uuid", csr_read_uuid, me.uuid);
          check("read_wid", csr_read_wid, me.wid);
          check("dup_read", got_read, 0);
          got_read = 1;
        end
      end
      if (csr_write_enable) begin
        if (exp_q.size() == 0) check("unexpected_write", exp_q.size(), 1);
        else begin
          me = exp_q[0];
          check("write_expected", csr_write_enable, me.do_write);
          check("write_cycle", cyc, me.read_cyc + 1);
          check("write_addr", csr_write_addr, me.addr);
          check("write_data", csr_write_data, me.wdata);
          check("write_uuid", csr_write_uuid, me.uuid);
          check("write_wid", csr_write_wid, me.wid);
          got_write = 1;
        end
      end
      if (rsp_valid) begin
        check("rsp_req_ready", req_ready, 0);
        check("rsp_busy", busy, 1);
        check("rsp_no_enable", csr_read_enable | csr_write_enable, 0);
        if (exp_q.size() == 0) check("unexpected_rsp", exp_q.size(), 1);
        else begin
          me = exp_q[0];
          if (!prev_valid) check("rsp_cycle", cyc, me.read_cyc + 2);
          else begin
            check("rsp_hold_data", rsp_data, prev_data);
            check("rsp_hold_uuid", rsp_uuid, prev_uuid);
            check("rsp_hold_wid", rsp_wid, prev_wid);
          end
          if (rsp_ready) begin
            check("rsp_data", rsp_data, me.old);
            check("rsp_uuid", rsp_uuid, me.uuid);
            check("rsp_wid", rsp_wid, me.wid);
            check("write_seen", got_write, me.do_write);
            check("read_seen", got_read, 1);
            void'(exp_q.pop_front());
            got_read = 0; got_write = 0; exp_idle = 1;
          end
        end
      end
      prev_valid = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
      prev_uuid  = rsp_uuid;
      prev_wid   = rsp_wid;
    end
  end

  // ---------------- driver + reference model ----------------
  // k: cycles fpu_pending[wid] stays high counting the accept cycle.
  // b: cycles rsp_ready is withheld once rsp_valid appears.
  task automatic do_txn(input int ai, input logic [1:0] op, input logic [31:0] operand,
                        input logic [NW_BITS-1:0] wid, input int k,
                        input logic [NUM_WARPS-1:0] other_pend, input int b);
    exp_t e;
    logic [11:0] a;
    logic [NUM_WARPS-1:0] pend;
    logic [31:0] nv;
    int stall;
    int n;
    a = addr_of(ai);
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("issue_ready", req_ready, 1);
    pend = other_pend;
    pend[wid] = (k > 0);
    stall = ((a == 12'h001) || (a == 12'h003)) && (k > 0) ? k : 0;
    e.uuid = UUID_BITS'({$urandom, $urandom});
    e.wid  = wid;
    e.addr = a;
    e.old  = ref_mem[ai];
    case (op)
      OP_RW:   nv = operand;
      OP_RS:   nv = e.old | operand;
      OP_RC:   nv = e.old & ~operand;
      default: nv = e.old;
    endcase
    e.do_write = (op == OP_RW) || (op != OP_READ && operand != 0);
    e.wdata = nv;
    if (e.do_write) ref_mem[ai] = nv;
`ifdef RV_CSR_CTRL_PERF_EN
    exp_stall  = (exp_stall + stall > 65535) ? 65535 : exp_stall + stall;
    exp_writes = (exp_writes + int'(e.do_write) > 65535) ? 65535 : exp_writes + int'(e.do_write);
`endif
    req_uuid = e.uuid; req_wid = wid; req_addr = a; req_op = op; req_operand = operand;
    fpu_pending = pend;
    req_valid = 1'b1;
    @(posedge clk); #1;
    e.read_cyc = cyc + stall;
    exp_q.push_back(e);
    req_valid = 1'b0;
    if (k > 1) begin repeat (k - 1) @(posedge clk); #1; end
    fpu_pending[wid] = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("rsp_timeout", rsp_valid, 1);
    repeat (b) @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) ref_mem[i] = $urandom;
    ref_mem[3] = 32'h0000_1234;
    ref_mem[4] = 32'h0000_00F0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rd_en", csr_read_enable, 0);
    check("rst_wr_en", csr_write_enable, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_uuid", rsp_uuid, 0);
    check("rst_wdata", csr_write_data, 0);
    reset = 1'b1;
    load_mem = 1'b0;

    // Reset asserted while in WRITE drops the write.
    @(posedge clk); #1;
    req_addr = 12'h305; req_op = OP_RW; req_operand = 32'hDEAD_BEEF;
    req_uuid = 44'h123; req_wid = 2'd1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_read_en", csr_read_enable, 1);
    @(posedge clk); #1;
    check("mid_write_en", csr_write_enable, 1);
    check("mid_write_data", csr_write_data, 32'hDEAD_BEEF);
    reset = 1'b0;
    #1;
    check("mid_rst_wr_en", csr_write_enable, 0);
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    check("mid_rst_no_write", dut_mem[5], ref_mem[5]);

    mon_en = 1'b1;
    // Directed: RW, RS, RC, RS with zero mask.
    do_txn(3, OP_RW, 32'h8000_0010, 2'd0, 0, '0, 0);
    do_txn(4, OP_RS, 32'h0000_000F, 2'd1, 0, '0, 0);
    do_txn(4, OP_RC, 32'h0000_0030, 2'd1, 0, '0, 0);
    do_txn(4, OP_RS, 32'h0000_0000, 2'd3, 0, '0, 0);
    check("rs_rc_value", ref_mem[4], 32'h0000_00CF);
    // FPU hold on fflags, no hold on frm, no hold on fcsr when another warp is busy.
    do_txn(0, OP_RS, 32'h0000_0001, 2'd2, 5, '0, 0);
    do_txn(1, OP_RW, 32'h0000_0007, 2'd2, 5, '0, 0);
    do_txn(2, OP_RW, 32'h0000_00AA, 2'd1, 0, 4'b1101, 0);
    do_txn(2, OP_READ, 32'hFFFF_FFFF, 2'd3, 3, '0, 0);
    // Back-pressure.
    do_txn(5, OP_RW, 32'h5555_AAAA, 2'd0, 0, '0, 4);

    // Random traffic.
    for (int t = 0; t < 150; t++) begin
      int ai, k, b;
      logic [1:0] op, w;
      logic [31:0] opnd;
      ai   = $urandom_range(0, 7);
      op   = 2'($urandom);
      opnd = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      w    = 2'($urandom);
      k    = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
      b    = $urandom_range(0, 3);
      do_txn(ai, op, opnd, w, k, NUM_WARPS'($urandom), b);
    end

    repeat (3) @(posedge clk); #1;
    check("queue_drained", exp_q.size(), 0);
    for (int i = 0; i < 8; i++) check("final_mem", dut_mem[i], ref_mem[i]);
`ifdef RV_CSR_CTRL_PERF_EN
    check("perf_stall", perf_fpu_stall_cycles, exp_stall);
    check("perf_writes", perf_csr_writes, exp_writes);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
